// File: rtl/matmul_tile_engine.sv
// Runtime-sized C = A*B tile engine: sequences LANES-wide chunk reads, multiplies lanes,
// reduces through a registered adder tree, accumulates over K-chunks and writes one result per element.
module matmul_tile_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int ADDR_IN_W  = 8,
  parameter int ADDR_OUT_W = 12,
  parameter int DIM_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DIM_W-1:0]              cfg_m,
  input  logic [DIM_W-1:0]              cfg_n,
  input  logic [DIM_W-1:0]              cfg_kt,
  input  logic                          cfg_sat,
  output logic                          busy,
  output logic                          done,
  output logic                          a_en,
  output logic                          b_en,
  output logic [ADDR_IN_W-1:0]          a_addr,
  output logic [ADDR_IN_W-1:0]          b_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   a_rdata,
  input  logic [LANES*DATA_WIDTH-1:0]   b_rdata,
  output logic                          out_we,
  output logic [ADDR_OUT_W-1:0]         out_addr,
  output logic [DATA_WIDTH-1:0]         out_wdata,
  output logic [1:0]                    dbg_state
);

  localparam int P     = $clog2(LANES);
  localparam int NODES = LANES - 1;
  localparam int STG   = P + 2;
  localparam int PW    = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  typedef struct packed {
    logic                  first;
    logic                  last;
    logic [ADDR_OUT_W-1:0] addr;
  } tag_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]      m_q, n_q, kt_q, i_q, j_q, k_q;
  logic                  sat_q;
  logic [ADDR_IN_W-1:0]  a_base_q, a_addr_q, b_addr_q, kt_w;
  logic [ADDR_OUT_W-1:0] o_addr_q;
  logic                  issue, k_last, j_last, i_last, zero_cfg, pipe_empty;

  logic [STG-1:0]        v_q;
  tag_t                  tag_q [STG];
  tag_t                  tag_in, tag_out;

  logic [PW-1:0]         a_x [LANES];
  logic [PW-1:0]         b_x [LANES];
  logic [PW-1:0]         prod_q [LANES];
  logic [ACC_WIDTH-1:0]  node_q [NODES];
  logic [ACC_WIDTH-1:0]  sum, acc_q, acc_d;
  logic [ACC_WIDTH-DATA_WIDTH:0] hi;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  out_we_q;
  logic [ADDR_OUT_W-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0] out_wdata_q;

  assign issue      = (state_q == S_RUN);
  assign k_last     = (k_q == kt_q - DIM_W'(1));
  assign j_last     = (j_q == n_q - DIM_W'(1));
  assign i_last     = (i_q == m_q - DIM_W'(1));
  assign zero_cfg   = (cfg_m == '0) || (cfg_n == '0) || (cfg_kt == '0);
  assign pipe_empty = ~|v_q;
  assign kt_w       = ADDR_IN_W'(kt_q);

  // Read port: a_en/b_en qualify a_addr/b_addr for one cycle; the memories return
  // data on the following cycle and there is no back-pressure.
  assign a_en      = issue;
  assign b_en      = issue;
  assign a_addr    = a_addr_q;
  assign b_addr    = b_addr_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_FIN);
  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_wdata = out_wdata_q;
  assign dbg_state = 2'(state_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // A zero-size job passes through DRAIN so busy is visible for one cycle before done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = zero_cfg ? S_DRAIN : S_RUN;
      S_RUN:   if (k_last && j_last && i_last) state_d = S_DRAIN;
      S_DRAIN: if (pipe_empty) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address generation by base counters: A restarts the current row per column, B streams then rewinds per row.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0; n_q <= '0; kt_q <= '0; sat_q <= 1'b0;
      i_q <= '0; j_q <= '0; k_q <= '0;
      a_base_q <= '0; a_addr_q <= '0; b_addr_q <= '0; o_addr_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      m_q <= cfg_m; n_q <= cfg_n; kt_q <= cfg_kt; sat_q <= cfg_sat;
      i_q <= '0; j_q <= '0; k_q <= '0;
      a_base_q <= '0; a_addr_q <= '0; b_addr_q <= '0; o_addr_q <= '0;
    end else if (issue) begin
      if (!k_last) begin
        k_q      <= k_q + DIM_W'(1);
        a_addr_q <= a_addr_q + ADDR_IN_W'(1);
        b_addr_q <= b_addr_q + ADDR_IN_W'(1);
      end else begin
        k_q      <= '0;
        o_addr_q <= o_addr_q + ADDR_OUT_W'(1);
        if (!j_last) begin
          j_q      <= j_q + DIM_W'(1);
          a_addr_q <= a_base_q;
          b_addr_q <= b_addr_q + ADDR_IN_W'(1);
        end else begin
          j_q      <= '0;
          i_q      <= i_q + DIM_W'(1);
          a_base_q <= a_base_q + kt_w;
          a_addr_q <= a_base_q + kt_w;
          b_addr_q <= '0;
        end
      end
    end
  end

  assign tag_in.first = (k_q == '0);
  assign tag_in.last  = k_last;
  assign tag_in.addr  = o_addr_q;
  assign tag_out      = tag_q[STG-1];

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= {v_q[STG-2:0], issue};
  end

  always_ff @(posedge clk) begin
    tag_q[0] <= tag_in;
    for (int s = 1; s < STG; s++) tag_q[s] <= tag_q[s-1];
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      a_x[l] = {{DATA_WIDTH{a_rdata[l*DATA_WIDTH+DATA_WIDTH-1]}}, a_rdata[l*DATA_WIDTH +: DATA_WIDTH]};
      b_x[l] = {{DATA_WIDTH{b_rdata[l*DATA_WIDTH+DATA_WIDTH-1]}}, b_rdata[l*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  // Low PW bits of the sign-extended product equal the exact signed product.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) prod_q[l] <= a_x[l] * b_x[l];
  end

  // Tree nodes are packed level by level: level s starts at LANES - (LANES >> (s-1)).
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES / 2; j++) begin
      node_q[j] <= {{(ACC_WIDTH-PW){prod_q[2*j][PW-1]}}, prod_q[2*j]}
                 + {{(ACC_WIDTH-PW){prod_q[2*j+1][PW-1]}}, prod_q[2*j+1]};
    end
    for (int s = 2; s <= P; s++) begin
      for (int j = 0; j < (LANES >> s); j++) begin
        node_q[LANES - (LANES >> (s-1)) + j] <= node_q[LANES - (LANES >> (s-2)) + 2*j]
                                              + node_q[LANES - (LANES >> (s-2)) + 2*j + 1];
      end
    end
  end

  assign sum = node_q[NODES-1];

  // Saturation is needed only when the bits above the output sign are not a pure sign extension.
  always_comb begin
    acc_d   = tag_out.first ? sum : acc_q + sum;
    hi      = acc_d[ACC_WIDTH-1:DATA_WIDTH-1];
    wdata_d = acc_d[DATA_WIDTH-1:0];
    if (sat_q && !((&hi) || !(|hi))) begin
      wdata_d = acc_d[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
    end else begin
      out_we_q <= v_q[STG-1] && tag_out.last;
      if (v_q[STG-1]) acc_q <= acc_d;
      if (v_q[STG-1] && tag_out.last) begin
        out_addr_q  <= tag_out.addr;
        out_wdata_q <= wdata_d;
      end
    end
  end

endmodule
